// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch-stage constants, slot record and reset helper
package fetch_pkg;

   localparam logic [31:0] NOP_INSTR_DEF = 32'h00000013;
   localparam int          FETCH_DW      = 32;
   localparam int          FETCH_IW      = 32;

   typedef struct packed {
      logic                valid;
      logic [FETCH_DW-1:0] pc;
      logic [FETCH_DW-1:0] pc_plus4;
      logic [FETCH_IW-1:0] instr;
   } fetch_slot_t;

   function automatic fetch_slot_t slot_reset();
      fetch_slot_t s;
      s.valid    = 1'b0;
      s.pc       = '0;
      s.pc_plus4 = '0;
      s.instr    = NOP_INSTR_DEF;
      return s;
   endfunction

endpackage

// File: rtl/fetch_pipe_slot.sv
// rtl/fetch_pipe_slot.sv - one fetch pipeline stage register (rst > flush > EN)
module fetch_pipe_slot
   import fetch_pkg::*;
#(
   parameter type   slot_t  = fetch_slot_t,
   parameter slot_t RST_VAL = slot_reset()
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  en_i,
   input  logic  flush_i,
   input  slot_t slot_i,
   output slot_t slot_o
);

   slot_t slot_q;
   slot_t slot_d;

   always_comb begin
      slot_d = slot_q;
      if (flush_i) begin
         slot_d = RST_VAL;
      end else if (en_i) begin
         slot_d = slot_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_q <= RST_VAL;
      end else begin
         slot_q <= slot_d;
      end
   end

   assign slot_o = slot_q;

endmodule

// File: rtl/fetch_pipe.sv
// rtl/fetch_pipe.sv - DEPTH-stage fetch register chain with flush and bubble counter
module fetch_pipe
   import fetch_pkg::*;
#(
   parameter int                     DATA_WIDTH  = 32,
   parameter int                     INSTR_WIDTH = 32,
   parameter int                     DEPTH       = 2,
   parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = INSTR_WIDTH'(NOP_INSTR_DEF),
   parameter int                     COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   EN,
   input  logic                   flush,
   input  logic                   valid_i,
   input  logic [DATA_WIDTH-1:0]  PCFi,
   input  logic [INSTR_WIDTH-1:0] instr_i,
   output logic [DATA_WIDTH-1:0]  PCFo,
   output logic [DATA_WIDTH-1:0]  PCPlus4o,
   output logic [INSTR_WIDTH-1:0] instr_o,
   output logic                   valid_o,
   output logic [COUNT_WIDTH-1:0] bubble_count
);

   typedef struct packed {
      logic                   valid;
      logic [DATA_WIDTH-1:0]  pc;
      logic [DATA_WIDTH-1:0]  pc_plus4;
      logic [INSTR_WIDTH-1:0] instr;
   } slot_t;

   localparam slot_t RST_SLOT = '{valid: 1'b0, pc: '0, pc_plus4: '0, instr: NOP_INSTR};
   localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

   // chain[0] is the combinational input slot; chain[k+1] is the output of stage k
   slot_t chain [DEPTH+1];

   assign chain[0] = '{valid:    valid_i,
                       pc:       PCFi,
                       pc_plus4: PCFi + DATA_WIDTH'(4),
                       instr:    instr_i};

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      fetch_pipe_slot #(
         .slot_t  (slot_t),
         .RST_VAL (RST_SLOT)
      ) u_slot (
         .clk     (clk),
         .rst     (rst),
         .en_i    (EN),
         .flush_i (flush),
         .slot_i  (chain[k]),
         .slot_o  (chain[k+1])
      );
   end

   assign PCFo     = chain[DEPTH].pc;
   assign PCPlus4o = chain[DEPTH].pc_plus4;
   assign instr_o  = chain[DEPTH].instr;
   assign valid_o  = chain[DEPTH].valid;

   logic [COUNT_WIDTH-1:0] count_q;
   logic [COUNT_WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (EN && !flush && !valid_o && (count_q != CNT_MAX)) begin
         count_d = count_q + COUNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign bubble_count = count_q;

endmodule

// File: tb/tb_fetch_pipe.sv
// tb/tb_fetch_pipe.sv - directed self-checking bench for fetch_pipe (DEPTH=2 and DEPTH=1)
module tb_fetch_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        flush;
   logic        valid_in;
   logic [31:0] pc_in;
   logic [31:0] instr_in;

   logic [31:0] pc2, pc4_2, ins2;
   logic        v2;
   logic [15:0] bc2;
   logic [31:0] pc1, pc4_1, ins1;
   logic        v1;
   logic [2:0]  bc1;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fetch_pipe #(.DEPTH(2), .COUNT_WIDTH(16)) u_dut2 (
      .clk(clk), .rst(rst), .EN(en), .flush(flush), .valid_i(valid_in),
      .PCFi(pc_in), .instr_i(instr_in), .PCFo(pc2), .PCPlus4o(pc4_2),
      .instr_o(ins2), .valid_o(v2), .bubble_count(bc2)
   );

   fetch_pipe #(.DEPTH(1), .COUNT_WIDTH(3)) u_dut1 (
      .clk(clk), .rst(rst), .EN(en), .flush(flush), .valid_i(valid_in),
      .PCFi(pc_in), .instr_i(instr_in), .PCFo(pc1), .PCPlus4o(pc4_1),
      .instr_o(ins1), .valid_o(v1), .bubble_count(bc1)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic e, input logic f, input logic v,
                        input logic [31:0] pc, input logic [31:0] ins);
      en       = e;
      flush    = f;
      valid_in = v;
      pc_in    = pc;
      instr_in = ins;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
      step();
      chk("rst_valid", 64'(v2), 64'h0);
      chk("rst_pc", 64'(pc2), 64'h0);
      chk("rst_pc4", 64'(pc4_2), 64'h0);
      chk("rst_instr", 64'(ins2), 64'h13);
      chk("rst_bc", 64'(bc2), 64'h0);
      rst = 1'b0;

      // streaming
      drive(1'b1, 1'b0, 1'b1, 32'h100, 32'hA100);
      step();
      chk("d1_lat1_pc", 64'(pc1), 64'h100);
      chk("d1_lat1_valid", 64'(v1), 64'h1);
      chk("d2_not_yet", 64'(v2), 64'h0);
      drive(1'b1, 1'b0, 1'b1, 32'h104, 32'hA104);
      step();
      chk("s0_pc", 64'(pc2), 64'h100);
      chk("s0_pc4", 64'(pc4_2), 64'h104);
      chk("s0_instr", 64'(ins2), 64'hA100);
      chk("s0_valid", 64'(v2), 64'h1);
      drive(1'b1, 1'b0, 1'b1, 32'h108, 32'hA108);
      step();
      chk("s1_pc", 64'(pc2), 64'h104);
      chk("s1_pc4", 64'(pc4_2), 64'h108);
      drive(1'b1, 1'b0, 1'b1, 32'h200, 32'hB200);
      step();
      chk("s2_pc", 64'(pc2), 64'h108);
      chk("s2_pc4", 64'(pc4_2), 64'h10C);
      chk("s2_bc", 64'(bc2), 64'h2);

      // stall: changing inputs must be ignored
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b1, 32'h999 + 32'(i), 32'h999);
         step();
      end
      chk("stall_pc", 64'(pc2), 64'h108);
      chk("stall_bc", 64'(bc2), 64'h2);
      chk("stall_d1_pc", 64'(pc1), 64'h200);

      // resume with an invalid slot carrying a payload
      drive(1'b1, 1'b0, 1'b0, 32'h55, 32'hDEAD);
      step();
      chk("resume_pc", 64'(pc2), 64'h200);
      chk("resume_pc4", 64'(pc4_2), 64'h204);
      chk("resume_valid", 64'(v2), 64'h1);
      chk("resume_bc", 64'(bc2), 64'h2);
      drive(1'b1, 1'b0, 1'b1, 32'h240, 32'hC240);
      step();
      chk("inv_valid", 64'(v2), 64'h0);
      chk("inv_pc", 64'(pc2), 64'h55);
      chk("inv_instr", 64'(ins2), 64'hDEAD);
      chk("inv_bc", 64'(bc2), 64'h2);

      // flush wins over EN=0 and discards the presented slot
      drive(1'b0, 1'b1, 1'b1, 32'h300, 32'hC300);
      step();
      chk("fl_valid", 64'(v2), 64'h0);
      chk("fl_pc", 64'(pc2), 64'h0);
      chk("fl_instr", 64'(ins2), 64'h13);
      chk("fl_bc", 64'(bc2), 64'h2);
      chk("fl_d1_valid", 64'(v1), 64'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
      chk("post_fl_pc", 64'(pc2), 64'h0);
      chk("post_fl_valid", 64'(v2), 64'h0);
      chk("post_fl_bc", 64'(bc2), 64'h3);

      // PC+4 wrap
      drive(1'b1, 1'b0, 1'b1, 32'hFFFFFFFC, 32'h1);
      step();
      chk("wrap_d1_pc4", 64'(pc4_1), 64'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
      chk("wrap_pc", 64'(pc2), 64'hFFFFFFFC);
      chk("wrap_pc4", 64'(pc4_2), 64'h0);
      chk("wrap_valid", 64'(v2), 64'h1);
      chk("wrap_bc", 64'(bc2), 64'h5);

      // asynchronous reset between edges
      #3;
      rst = 1'b1;
      #1;
      chk("arst_valid", 64'(v2), 64'h0);
      chk("arst_pc", 64'(pc2), 64'h0);
      chk("arst_pc4", 64'(pc4_2), 64'h0);
      chk("arst_instr", 64'(ins2), 64'h13);
      chk("arst_bc", 64'(bc2), 64'h0);
      step();
      rst = 1'b0;

      // saturation of the 3-bit counter
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int k = 1; k <= 12; k++) begin
         step();
         if (k == 3)  chk("sat_k3", 64'(bc1), 64'h3);
         if (k == 7)  chk("sat_k7", 64'(bc1), 64'h7);
      end
      chk("sat_k12", 64'(bc1), 64'h7);
      chk("nosat_k12", 64'(bc2), 64'd12);
      drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
      step();
      step();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
      step();
      chk("sat_hold", 64'(bc1), 64'h7);
      chk("nosat_hold", 64'(bc2), 64'd12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_pipe.md
Name: fetch_pipe

Overview:
Parametrised fetch-side pipeline register chain, the successor to the single fixed fetch register. It carries PC, PC+4, instruction and a valid bit through DEPTH enable-gated stages into decode. It adds asynchronous reset, a synchronous flush for branch/jump redirects, and a saturating bubble counter for performance monitoring.

Parameters:
DATA_WIDTH, 32, width of PC and PC+4 fields
INSTR_WIDTH, 32, width of instruction field
DEPTH, 2, number of register stages (legal range 1..8)
NOP_INSTR, 32'h00000013, instruction value loaded on reset/flush (addi x0,x0,0)
COUNT_WIDTH, 16, width of bubble counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
EN  in  1  advance enable; 0 = stall, all stages hold
flush  in  1  synchronous flush of all stages
valid_i  in  1  input slot carries a real instruction
PCFi  in  DATA_WIDTH  fetch PC
instr_i  in  INSTR_WIDTH  fetched instruction
PCFo  out  DATA_WIDTH  PC at last stage
PCPlus4o  out  DATA_WIDTH  PC+4 at last stage
instr_o  out  INSTR_WIDTH  instruction at last stage
valid_o  out  1  valid bit at last stage
bubble_count  out  COUNT_WIDTH  saturating count of enabled cycles with valid_o=0

Behaviour:
- Reset (rst=1, asynchronous, any time including mid-stall/flush): every stage valid=0, PC=0, PC+4=0, instr=NOP_INSTR; bubble_count=0. Outputs reflect this immediately, not on the next edge.
- Structure: stage[0]..stage[DEPTH-1]. Outputs are driven directly from stage[DEPTH-1] with no combinational path from inputs.
- Advance (EN=1, flush=0):
  - stage[0] <= {valid_i, PCFi, PCFi+4, instr_i}; stage[k] <= stage[k-1].
  - Latency from input to output is exactly DEPTH enabled edges.
- PC+4: computed at stage-0 capture, modulo 2^DATA_WIDTH. 0xFFFFFFFC gives 0x00000000 (wrap, no flag).
- Stall (EN=0, flush=0): all stages hold, bubble_count holds.
- Flush (flush=1): on the next edge every stage is loaded with the reset value, regardless of EN. flush has priority over EN. The input slot presented in the flush cycle is discarded even if valid_i=1.
- Invalid inputs (valid_i=0) are captured as-is; payload is don't-care but must propagate unchanged.
- bubble_count: at each edge with EN=1 and flush=0, if the current valid_o=0, increment; saturate at 2^COUNT_WIDTH-1. Flush cycles do not count. Stall cycles do not count. Only rst clears it.
- DEPTH=1: single stage, behaviour identical to the above with latency 1.
- Cycle following flush deassertion: the chain resumes normal advance.

Decomposition:
- Package fetch_pkg:
  - NOP_INSTR default constant.
  - Parametrised stage record typedef fetch_slot_t {valid, pc, pc_plus4, instr}.
  - Function slot_reset() returning the reset slot value.
- Sub-module fetch_pipe_slot: one stage register with rst/EN/flush priority (rst > flush > EN) and a slot_t in/out. fetch_pipe instantiates DEPTH of these in a generate loop, plus the PC+4 adder and the bubble counter.

Test Plan:
- Reset check: assert rst mid-run with DEPTH=2 -> immediately valid_o=0, PCFo=0, PCPlus4o=0, instr_o=0x00000013, bubble_count=0.
- Streaming: EN=1, valid_i=1, PCFi=0x100,0x104,0x108 on consecutive edges -> outputs appear 2 edges later in order: PCFo=0x100/PCPlus4o=0x104, then 0x104/0x108, then 0x108/0x10C.
- Stall: stream PCFi=0x200, then hold EN=0 for 3 cycles -> outputs and bubble_count frozen; on resume, 0x200 emerges after the remaining enabled edges, with no duplication or loss.
- Flush priority: EN=0, flush=1, valid_i=1, PCFi=0x300 -> next edge all stages invalid, instr_o=0x00000013, 0x300 never appears at the output, bubble_count unchanged that edge.
- PC wrap: PCFi=0xFFFFFFFC -> after DEPTH edges PCPlus4o=0x00000000.
- Counter saturation: COUNT_WIDTH=3, EN=1, valid_i=0 for 12 cycles -> bubble_count counts up and stops at 7. Then drive flush and EN=0 cycles -> bubble_count stays at 7.
